// File: rtl/csr_unit.sv
// Machine-mode CSR unit: CSRRW/CSRRS/CSRRC access, ECALL/MRET trap stacking,
// 64-bit cycle/instret counters, read-only ID registers and illegal-access
// detection. Read data and redirect outputs are combinational; all state
// updates land on the rising clock edge.
module csr_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_MTVEC  = '0,
   parameter logic [XLEN-1:0] ECALL_CAUSE  = XLEN'(11),
   parameter int              HAS_COUNTERS = 1,
   parameter logic [XLEN-1:0] MVENDORID    = '0,
   parameter logic [XLEN-1:0] MARCHID      = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            op_valid,
   input  logic [2:0]      op,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] wdata,
   input  logic            wr_suppress,
   input  logic [XLEN-1:0] pc,
   input  logic            retire,
   output logic [XLEN-1:0] rdata,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            illegal,
   output logic            mie_out
);

   localparam logic [11:0] A_SATP      = 12'h180;
   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_MVENDORID = 12'hF11;
   localparam logic [11:0] A_MARCHID   = 12'hF12;

   localparam logic [2:0] OP_CSRRW = 3'd0;
   localparam logic [2:0] OP_CSRRS = 3'd1;
   localparam logic [2:0] OP_CSRRC = 3'd2;
   localparam logic [2:0] OP_ECALL = 3'd3;
   localparam logic [2:0] OP_MRET  = 3'd4;

   localparam bit CNT_EN  = (HAS_COUNTERS != 0);
   localparam bit HALVES  = CNT_EN && (XLEN == 32);

   logic            r_mie;
   logic            r_mpie;
   logic [XLEN-1:0] r_satp;
   logic [XLEN-1:0] r_mtvec;
   logic [XLEN-1:0] r_mscratch;
   logic [XLEN-1:0] r_mepc;
   logic [XLEN-1:0] r_mcause;
   logic [63:0]     r_mcycle;
   logic [63:0]     r_minstret;

   // Internally everything is handled at 64 bits so one datapath serves both XLENs.
   logic [63:0]     w_old;
   logic [63:0]     w_opnd;
   logic [63:0]     w_new;
   logic            w_mapped;
   logic            w_ro;
   logic            w_is_csr_op;
   logic            w_no_write;
   logic            w_illegal;
   logic            w_we;
   logic            w_ecall;
   logic            w_mret;

   // Address decode, old-value mux and read-modify-write result.
   always_comb begin
      w_old    = '0;
      w_mapped = 1'b0;
      w_ro     = 1'b0;
      case (csr_addr)
         A_SATP:      begin w_mapped = 1'b1; w_old = 64'(r_satp);     end
         A_MSTATUS:   begin
            w_mapped     = 1'b1;
            w_old[12:11] = 2'b11;
            w_old[7]     = r_mpie;
            w_old[3]     = r_mie;
         end
         A_MTVEC:     begin w_mapped = 1'b1; w_old = 64'(r_mtvec);    end
         A_MSCRATCH:  begin w_mapped = 1'b1; w_old = 64'(r_mscratch); end
         A_MEPC:      begin w_mapped = 1'b1; w_old = 64'(r_mepc);     end
         A_MCAUSE:    begin w_mapped = 1'b1; w_old = 64'(r_mcause);   end
         A_MCYCLE:    begin
            w_mapped = CNT_EN;
            w_old    = (XLEN == 64) ? r_mcycle : {32'h0, r_mcycle[31:0]};
         end
         A_MINSTRET:  begin
            w_mapped = CNT_EN;
            w_old    = (XLEN == 64) ? r_minstret : {32'h0, r_minstret[31:0]};
         end
         A_MCYCLEH:   begin w_mapped = HALVES; w_old = {32'h0, r_mcycle[63:32]};   end
         A_MINSTRETH: begin w_mapped = HALVES; w_old = {32'h0, r_minstret[63:32]}; end
         A_MVENDORID: begin w_mapped = 1'b1; w_ro = 1'b1; w_old = 64'(MVENDORID); end
         A_MARCHID:   begin w_mapped = 1'b1; w_ro = 1'b1; w_old = 64'(MARCHID);   end
         default:     begin w_mapped = 1'b0; w_old = '0; end
      endcase
      if (!w_mapped) w_old = '0;

      w_opnd = 64'(wdata);
      case (op)
         OP_CSRRW: w_new = w_opnd;
         OP_CSRRS: w_new = w_old | w_opnd;
         OP_CSRRC: w_new = w_old & ~w_opnd;
         default:  w_new = w_old;
      endcase

      // rs1=x0 on set/clear turns the access into a pure read.
      w_is_csr_op = (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
      w_no_write  = wr_suppress && (op != OP_CSRRW);
      w_illegal   = 1'b0;
      if (op_valid) begin
         if (op > OP_MRET)
            w_illegal = 1'b1;
         else if (w_is_csr_op)
            w_illegal = !w_mapped || (w_ro && !w_no_write);
      end
      w_we    = op_valid && w_is_csr_op && !w_illegal && !w_no_write;
      w_ecall = op_valid && (op == OP_ECALL);
      w_mret  = op_valid && (op == OP_MRET);
   end

   assign rdata          = w_old[XLEN-1:0];
   assign illegal        = w_illegal;
   assign redirect_valid = w_ecall || w_mret;
   assign redirect_pc    = w_ecall ? r_mtvec : r_mepc;
   assign mie_out        = r_mie;

   // CSR state, trap stacking and counters; a CSR write to a counter half drops that cycle's increment.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_mie      <= 1'b0;
         r_mpie     <= 1'b0;
         r_satp     <= '0;
         r_mtvec    <= RESET_MTVEC;
         r_mscratch <= '0;
         r_mepc     <= '0;
         r_mcause   <= '0;
         r_mcycle   <= '0;
         r_minstret <= '0;
      end else begin
         if (w_we) begin
            case (csr_addr)
               A_SATP:     r_satp     <= w_new[XLEN-1:0];
               A_MSTATUS:  begin r_mie <= w_new[3]; r_mpie <= w_new[7]; end
               A_MTVEC:    r_mtvec    <= {w_new[XLEN-1:2], 2'b00};
               A_MSCRATCH: r_mscratch <= w_new[XLEN-1:0];
               A_MEPC:     r_mepc     <= {w_new[XLEN-1:2], 2'b00};
               A_MCAUSE:   r_mcause   <= w_new[XLEN-1:0];
               default:    ;
            endcase
         end

         if (w_ecall) begin
            r_mepc   <= pc & ~XLEN'(3);
            r_mcause <= ECALL_CAUSE;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
         end else if (w_mret) begin
            r_mie    <= r_mpie;
            r_mpie   <= 1'b1;
         end

         if (CNT_EN) begin
            if (w_we && csr_addr == A_MCYCLE)
               r_mcycle <= (XLEN == 64) ? w_new : {r_mcycle[63:32], w_new[31:0]};
            else if (w_we && csr_addr == A_MCYCLEH)
               r_mcycle <= {w_new[31:0], r_mcycle[31:0]};
            else
               r_mcycle <= r_mcycle + 64'd1;

            if (w_we && csr_addr == A_MINSTRET)
               r_minstret <= (XLEN == 64) ? w_new : {r_minstret[63:32], w_new[31:0]};
            else if (w_we && csr_addr == A_MINSTRETH)
               r_minstret <= {w_new[31:0], r_minstret[31:0]};
            else if (retire)
               r_minstret <= r_minstret + 64'd1;
         end
      end
   end

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit (XLEN=32): directed steps followed by random operations,
// every cycle compared against a behavioural CSR model.
module tb_csr_unit;

   localparam logic [31:0] RST_MTVEC = 32'h8000_0100;
   localparam logic [31:0] VENDOR    = 32'h0000_0489;
   localparam logic [31:0] ARCH      = 32'h0000_0005;

   logic        clk;
   logic        rst;
   logic        op_valid;
   logic [2:0]  op;
   logic [11:0] csr_addr;
   logic [31:0] wdata;
   logic        wr_suppress;
   logic [31:0] pc;
   logic        retire;
   logic [31:0] rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        illegal;
   logic        mie_out;

   int passed = 0;
   int total  = 0;

   csr_unit #(
      .XLEN(32), .RESET_MTVEC(RST_MTVEC), .ECALL_CAUSE(32'd11),
      .HAS_COUNTERS(1), .MVENDORID(VENDOR), .MARCHID(ARCH)
   ) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .csr_addr(csr_addr),
      .wdata(wdata), .wr_suppress(wr_suppress), .pc(pc), .retire(retire),
      .rdata(rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .illegal(illegal), .mie_out(mie_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit [31:0] m_satp, m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause;
   bit [63:0] m_cyc, m_ins;

   function automatic void m_reset();
      m_satp = 0; m_mstatus = 32'h1800; m_mtvec = RST_MTVEC;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cyc = 0; m_ins = 0;
   endfunction

   function automatic void m_read(input bit [11:0] a, output bit legal, output bit ro,
                                  output bit [31:0] v);
      legal = 1; ro = 0; v = 0;
      case (a)
         12'h180: v = m_satp;
         12'h300: v = m_mstatus;
         12'h305: v = m_mtvec;
         12'h340: v = m_mscratch;
         12'h341: v = m_mepc;
         12'h342: v = m_mcause;
         12'hB00: v = m_cyc[31:0];
         12'hB80: v = m_cyc[63:32];
         12'hB02: v = m_ins[31:0];
         12'hB82: v = m_ins[63:32];
         12'hF11: begin v = VENDOR; ro = 1; end
         12'hF12: begin v = ARCH;   ro = 1; end
         default: legal = 0;
      endcase
   endfunction

   function automatic bit m_illegal();
      bit lg, ro; bit [31:0] v;
      m_read(csr_addr, lg, ro, v);
      if (!op_valid) return 0;
      if (op >= 5) return 1;
      if (op >= 3) return 0;
      if (!lg) return 1;
      return ro && !(wr_suppress && op != 0);
   endfunction

   function automatic void m_step();
      bit lg, ro, wr, cyc_w, ins_w; bit [31:0] old, nv;
      if (!rst) begin m_reset(); return; end
      m_read(csr_addr, lg, ro, old);
      wr = op_valid && op <= 2 && !m_illegal() && !(wr_suppress && op != 0);
      cyc_w = 0; ins_w = 0;
      if (wr) begin
         nv = (op == 0) ? wdata : (op == 1) ? (old | wdata) : (old & ~wdata);
         case (csr_addr)
            12'h180: m_satp = nv;
            12'h300: m_mstatus = (nv & 32'h88) | 32'h1800;
            12'h305: m_mtvec = nv & ~32'h3;
            12'h340: m_mscratch = nv;
            12'h341: m_mepc = nv & ~32'h3;
            12'h342: m_mcause = nv;
            12'hB00: begin m_cyc[31:0]  = nv; cyc_w = 1; end
            12'hB80: begin m_cyc[63:32] = nv; cyc_w = 1; end
            12'hB02: begin m_ins[31:0]  = nv; ins_w = 1; end
            12'hB82: begin m_ins[63:32] = nv; ins_w = 1; end
            default: ;
         endcase
      end
      if (op_valid && op == 3) begin
         m_mepc = pc & ~32'h3; m_mcause = 11;
         m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
      end else if (op_valid && op == 4) begin
         m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
      end
      if (!cyc_w) m_cyc = m_cyc + 1;
      if (!ins_w && retire) m_ins = m_ins + 1;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Drive one cycle's inputs and compare all outputs with the model before the edge.
   task automatic op_cyc(input bit rn, input bit v, input bit [2:0] o, input bit [11:0] a,
                         input bit [31:0] w, input bit s, input bit [31:0] p, input bit r);
      bit lg, ro, exp_rv; bit [31:0] ev;
      rst = rn; op_valid = v; op = o; csr_addr = a; wdata = w;
      wr_suppress = s; pc = p; retire = r;
      @(negedge clk);
      m_read(a, lg, ro, ev);
      chk("rdata", rdata, lg ? ev : 32'h0);
      chk("illegal", illegal, m_illegal());
      exp_rv = v && (o == 3 || o == 4);
      chk("redirect_valid", redirect_valid, exp_rv);
      if (exp_rv) chk("redirect_pc", redirect_pc, (o == 3) ? m_mtvec : m_mepc);
      chk("mie_out", mie_out, m_mstatus[3]);
   endtask

   task automatic tick();
      @(posedge clk);
      m_step();
      #1;
   endtask

   task automatic rd(input bit [11:0] a);
      op_cyc(1, 0, 0, a, 0, 0, 0, 0);
   endtask

   bit [11:0] addr_tab [15] = '{12'h180, 12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11, 12'hF12,
                                12'h7C0, 12'hB81, 12'h301};

   initial begin
      bit [31:0] h0, lo0;
      bit [2:0]  ro_op;
      int        sel;
      rst = 0; op_valid = 0; op = 0; csr_addr = 0; wdata = 0;
      wr_suppress = 0; pc = 0; retire = 0;
      repeat (2) @(posedge clk);
      #1;
      m_reset();

      // reset values, read while reset still held
      op_cyc(0, 0, 0, 12'h300, 0, 0, 0, 0); chk("rst_mstatus", rdata, 32'h1800); tick();
      op_cyc(0, 0, 0, 12'h305, 0, 0, 0, 0); chk("rst_mtvec", rdata, 32'h8000_0100); tick();
      op_cyc(0, 0, 0, 12'h341, 0, 0, 0, 0); chk("rst_mepc", rdata, 0);
      rst = 1; tick();
      rd(12'hB00); chk("mcycle_first", rdata, 1); tick();
      rd(12'hB00); tick();
      rd(12'hB00); chk("mcycle_third", rdata, 3); tick();

      // mscratch read-modify-write
      op_cyc(1, 1, 0, 12'h340, 32'hDEAD_BEEF, 0, 0, 0); chk("rw_old", rdata, 0); tick();
      op_cyc(1, 1, 1, 12'h340, 32'h10, 0, 0, 0); chk("rs_old", rdata, 32'hDEAD_BEEF); tick();
      op_cyc(1, 1, 2, 12'h340, 32'hF, 0, 0, 0); chk("rc_old", rdata, 32'hDEAD_BEFF); tick();
      rd(12'h340); chk("mscratch_final", rdata, 32'hDEAD_BEF0); tick();

      // trap entry and return
      op_cyc(1, 1, 1, 12'h300, 32'h8, 0, 0, 1); tick();
      op_cyc(1, 1, 3, 12'h000, 0, 0, 32'h8000_0044, 1);
      chk("ecall_rv", redirect_valid, 1); chk("ecall_pc", redirect_pc, 32'h8000_0100); tick();
      rd(12'h341); chk("ecall_mepc", rdata, 32'h8000_0044); tick();
      rd(12'h342); chk("ecall_mcause", rdata, 11); tick();
      rd(12'h300); chk("ecall_mstatus", rdata, 32'h1880); chk("ecall_mie", mie_out, 0); tick();
      op_cyc(1, 1, 4, 12'h000, 0, 0, 0, 0); chk("mret_pc", redirect_pc, 32'h8000_0044); tick();
      rd(12'h300); chk("mret_mstatus", rdata, 32'h1888); tick();

      // illegal accesses
      op_cyc(1, 1, 0, 12'hF11, 32'h1, 0, 0, 0); chk("ro_write_ill", illegal, 1); tick();
      op_cyc(1, 1, 1, 12'hF11, 32'h0, 1, 0, 0);
      chk("ro_read_ill", illegal, 0); chk("ro_read_val", rdata, VENDOR); tick();
      op_cyc(1, 1, 2, 12'hF12, 32'h0, 0, 0, 0); chk("ro_rc_ill", illegal, 1); tick();
      op_cyc(1, 1, 0, 12'h7C0, 32'h1234, 0, 0, 0);
      chk("unmapped_ill", illegal, 1); chk("unmapped_rd", rdata, 0); tick();
      op_cyc(1, 1, 6, 12'h340, 32'h0, 0, 0, 0); chk("resv_op_ill", illegal, 1); tick();
      rd(12'h340); chk("no_change", rdata, 32'hDEAD_BEF0); tick();

      // counter/write collisions and wrap
      h0 = m_cyc[63:32];
      op_cyc(1, 1, 0, 12'hB00, 32'hFFFF_FFFF, 0, 0, 1); tick();
      rd(12'hB00); chk("mcycle_lo_wr", rdata, 32'hFFFF_FFFF); tick();
      rd(12'hB00); chk("mcycle_lo_carry", rdata, 0); tick();
      rd(12'hB80); chk("mcycle_hi_carry", rdata, h0 + 1); tick();
      lo0 = m_ins[31:0];
      op_cyc(1, 1, 0, 12'hB82, 32'h5, 0, 0, 1); tick();
      rd(12'hB82); chk("minstret_hi_wr", rdata, 5); tick();
      rd(12'hB02); chk("minstret_lo_keep", rdata, lo0); tick();
      op_cyc(1, 1, 0, 12'hB80, 32'hFFFF_FFFF, 0, 0, 0); tick();
      op_cyc(1, 1, 0, 12'hB00, 32'hFFFF_FFFF, 0, 0, 0); tick();
      rd(12'hB80); chk("wrap_pre_hi", rdata, 32'hFFFF_FFFF); tick();
      rd(12'hB80); chk("wrap_hi", rdata, 0); tick();
      rd(12'hB00); chk("wrap_lo", rdata, 1); tick();

      // reset beats a concurrent ECALL
      op_cyc(0, 1, 3, 12'h000, 0, 0, 32'h1234_5678, 1); tick();
      rd(12'h341); chk("rst_ecall_mepc", rdata, 0); tick();
      rd(12'h342); chk("rst_ecall_mcause", rdata, 0); tick();
      rd(12'h300); chk("rst_ecall_mstatus", rdata, 32'h1800); tick();
      rd(12'h340); chk("rst_mscratch", rdata, 0); tick();

      // random traffic against the model
      for (int i = 0; i < 500; i++) begin
         sel = $urandom_range(0, 9);
         ro_op = (sel < 7) ? 3'($urandom_range(0, 2)) : (sel == 7) ? 3'd3 :
                 (sel == 8) ? 3'd4 : 3'($urandom_range(5, 7));
         op_cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 9) != 0), ro_op,
                addr_tab[$urandom_range(0, 14)],
                ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom(),
                ($urandom_range(0, 3) == 0), $urandom() & ~32'h3, 1'($urandom_range(0, 1)));
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Parametrised machine-mode CSR unit; successor to the fixed 5-register CSR file.
- Adds the following over the previous block:
  - CSRRS/CSRRC set/clear ops
  - mstatus MIE/MPIE stacking on trap entry/return
  - 64-bit mcycle/minstret counters
  - mscratch and read-only ID CSRs
  - illegal-access detection
- Sits beside the register file in the execute/writeback stage. Supplies CSR read data and the trap/return redirect PC to the PC mux.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64.
- RESET_MTVEC, 0, reset value of mtvec.
- ECALL_CAUSE, 11, value written to mcause on ECALL (M-mode environment call).
- HAS_COUNTERS, 1, if 0 mcycle/minstret and their h-halves are unmapped (illegal).
- MVENDORID, 0, read-only value returned for 0xF11.
- MARCHID, 0, read-only value returned for 0xF12.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- op_valid  in  1  an operation is presented this cycle.
- op  in  3  0=CSRRW, 1=CSRRS, 2=CSRRC, 3=ECALL, 4=MRET; 5-7 reserved (no-op, illegal=1).
- csr_addr  in  12  CSR address for ops 0-2.
- wdata  in  XLEN  rs1/zimm operand.
- wr_suppress  in  1  CSRRS/CSRRC with rs1=x0: read only, no write, no illegal on RO CSRs.
- pc  in  XLEN  PC of the current instruction.
- retire  in  1  one instruction retires this cycle.
- rdata  out  XLEN  old CSR value (combinational from csr_addr).
- redirect_valid  out  1  trap/return taken this cycle (combinational).
- redirect_pc  out  XLEN  trap/return target.
- illegal  out  1  access rejected (combinational); no state change occurs.
- mie_out  out  1  current mstatus.MIE.

Behaviour:
- Address map:
  - 0x180 satp
  - 0x300 mstatus
  - 0x305 mtvec
  - 0x340 mscratch
  - 0x341 mepc
  - 0x342 mcause
  - 0xB00/0xB80 mcycle lo/hi
  - 0xB02/0xB82 minstret lo/hi
  - 0xF11 mvendorid (RO)
  - 0xF12 marchid (RO)
- Illegal accesses:
  - h-halves (0xB80/0xB82) are illegal when XLEN=64; 0xB00/0xB02 then return the full 64 bits.
  - Any other address is illegal; rdata=0 for illegal addresses.
- Reset, when rst=0 at an edge:
  - mstatus=0x1800 (MPP=11, MIE=MPIE=0)
  - mtvec=RESET_MTVEC
  - all other CSRs and counters = 0
  - Reset overrides every concurrent op/retire.
- Reset-time outputs: redirect_valid=0, illegal=0 while op_valid=0.
- Write timing: all writes commit at the rising edge while op_valid=1 and illegal=0. rdata in the same cycle shows the pre-write value. The new value is visible the next cycle.
- CSRRW: new = wdata.
- CSRRS: new = old | wdata.
- CSRRC: new = old & ~wdata.
- Writes to RO CSRs (0xF11/0xF12) with ops 0-2 are illegal unless wr_suppress=1 on CSRRS/CSRRC.
- mstatus write mask: only MIE (bit3) and MPIE (bit7) are writable; MPP (12:11) is hardwired 11; all other bits read 0.
- mtvec: bits[1:0] forced to 0 on write (direct mode only).
- mepc: bits[1:0] forced to 0 on write.
- ECALL, when op_valid=1, op=3:
  - Combinational outputs that cycle: redirect_valid=1, redirect_pc=mtvec.
  - At the edge: mepc<=pc, mcause<=ECALL_CAUSE, MPIE<=MIE, MIE<=0.
- MRET, when op_valid=1, op=4:
  - Combinational outputs that cycle: redirect_valid=1, redirect_pc=mepc.
  - At the edge: MIE<=MPIE, MPIE<=1.
- Counters (HAS_COUNTERS=1):
  - mcycle increments by 1 every cycle out of reset.
  - minstret increments by 1 on each cycle with retire=1.
  - Both are 64-bit and wrap from 2^64-1 to 0.
- Counter/write collisions:
  - A CSR write to any half of a counter in the same cycle as its increment: the written half takes the write value; the other half keeps its current value; the increment is dropped that cycle.
  - The low-half carry does not propagate into a written high half.
- ECALL/MRET with retire=1: minstret still increments.
- Back-to-back ops: each cycle is independent, no stall. An ECALL immediately followed by MRET returns to the pc of the ECALL.

Test Plan:
- Reset with RESET_MTVEC=0x80000100:
  - read 0x300 -> 0x00001800; 0x305 -> 0x80000100; 0x341 -> 0.
  - 0xB00 reads 1 the cycle after reset is released and 3 after two more cycles.
- CSRRW 0x340 wdata=0xDEADBEEF -> rdata=0 that cycle. Then CSRRS 0x340 wdata=0x10 -> rdata=0xDEADBEEF. Then CSRRC 0x340 wdata=0xF -> rdata=0xDEADBEFF. Final read -> 0xDEADBEF0.
- Set MIE via CSRRS 0x300 wdata=0x8; ECALL pc=0x80000044:
  - same cycle: redirect_valid=1, redirect_pc=mtvec.
  - next cycle: mepc=0x80000044, mcause=11, mstatus=0x1880, mie_out=0.
  - then MRET: redirect_pc=0x80000044; mstatus=0x1888.
- Illegal cases:
  - CSRRW 0xF11 -> illegal=1, no change.
  - CSRRS 0xF11 wr_suppress=1 -> illegal=0, rdata=MVENDORID.
  - CSRRW 0x7C0 -> illegal=1, rdata=0, no CSR changes.
- Counter collision:
  - CSRRW 0xB00 wdata=0xFFFFFFFF with retire=1 -> next cycle mcycle lo=0xFFFFFFFF.
  - the following cycle lo=0, hi incremented by 1.
  - CSRRW 0xB82 wdata=5 with retire=1 -> minstret hi=5, lo unchanged.
- Assert rst=0 in the same cycle as an ECALL -> no mepc/mcause update; all CSRs at reset values the next cycle.
